seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 23 ++
 rtl/addsub_n.sv | 28 ++
 rtl/seq_divider.sv | 136 +++++++++++++
 tb/tb_seq_divider.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   N_DEF       : default operand width in bits
//   state_t     : controller states IDLE / RUN / DONE
//   CNT_W       : step-counter width for the default width
//   count_width : step-counter width for an arbitrary operand width
package seq_divider_pkg;

    localparam int unsigned N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must hold the value n itself, hence n+1 codes.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned CNT_W = count_width(N_DEF);

endpackage

// File: rtl/addsub_n.sv
// Width-parameterised ripple-carry adder/subtractor.
//   a, b  : W-bit operands
//   mode  : 0 = add (a + b), 1 = subtract (a - b, two's complement)
//   s     : W-bit result (carry out discarded; sign read from s[W-1])
module addsub_n #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W-1:0] s
);

    // Subtraction is a + ~b + 1: invert b and feed mode in as carry-in.
    // Each loop iteration is one full-adder stage of the ripple chain.
    always_comb begin
        logic [W-1:0] bx;
        logic         c;
        bx = b ^ {W{mode}};
        c  = mode;
        s  = '0;
        for (int unsigned i = 0; i < W; i++) begin
            s[i] = a[i] ^ bx[i] ^ c;
            c    = (a[i] & bx[i]) | (a[i] & c) | (bx[i] & c);
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   start   : begin a division (sampled in IDLE only)
//   x, y    : N-bit unsigned dividend / divisor
//   busy    : high while iterating (RUN)
//   done    : one-cycle completion pulse (DONE)
//   q, r    : quotient / remainder, held until the next completion
//   divzero : last result came from a zero divisor (q = all ones, r = x)
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         divzero
);

    localparam int unsigned CW = count_width(N);

    state_t        state, state_n;
    logic [N:0]    a_reg, a_n;
    logic [N-1:0]  qw_reg, qw_n;
    logic [N-1:0]  y_reg, y_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  q_n, r_n;
    logic          divzero_n;

    logic [2*N:0]  aq_sh;
    logic [N:0]    a_sh;
    logic [N-1:0]  q_sh;
    logic [N:0]    diff;
    logic [N:0]    step_a;
    logic [N-1:0]  step_q;

    // Shift {A,Q} left by one; A's MSB falls off (A < Y before the shift).
    always_comb begin
        aq_sh = {a_reg, qw_reg} << 1;
        a_sh  = aq_sh[2*N:N];
        q_sh  = aq_sh[N-1:0];
    end

    addsub_n #(.W(N + 1)) u_addsub (
        .a    (a_sh),
        .b    ({1'b0, y_reg}),
        .mode (1'b1),
        .s    (diff)
    );

    // Restore on a negative difference; the quotient bit is the inverted sign.
    always_comb begin
        step_a    = diff[N] ? a_sh : diff;
        step_q    = q_sh;
        step_q[0] = ~diff[N];
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_n   = state;
        a_n       = a_reg;
        qw_n      = qw_reg;
        y_n       = y_reg;
        cnt_n     = cnt;
        q_n       = q;
        r_n       = r;
        divzero_n = divzero;
        case (state)
            IDLE: begin
                if (start) begin
                    if (y == '0) begin
                        state_n   = DONE;
                        q_n       = '1;
                        r_n       = x;
                        divzero_n = 1'b1;
                    end else begin
                        state_n = RUN;
                        y_n     = y;
                        a_n     = '0;
                        qw_n    = x;
                        cnt_n   = CW'(N);
                    end
                end
            end
            RUN: begin
                a_n   = step_a;
                qw_n  = step_q;
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n   = DONE;
                    q_n       = step_q;
                    r_n       = step_a[N-1:0];
                    divzero_n = 1'b0;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            qw_reg  <= '0;
            y_reg   <= '0;
            cnt     <= '0;
            q       <= '0;
            r       <= '0;
            divzero <= 1'b0;
        end else begin
            state   <= state_n;
            a_reg   <= a_n;
            qw_reg  <= qw_n;
            y_reg   <= y_n;
            cnt     <= cnt_n;
            q       <= q_n;
            r       <= r_n;
            divzero <= divzero_n;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N = 4): directed vector table,
// reset-abort sequence, and an exhaustive sweep of x and nonzero y.
module tb_seq_divider;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         divzero;

    int n_checks = 0;
    int n_fail   = 0;
    int prev_q   = 0;
    int prev_r   = 0;

    typedef struct {
        logic [N-1:0] vx;
        logic [N-1:0] vy;
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic         edz;
        bit           restart;
        string        name;
    } vec_t;

    vec_t vecs[6];

    seq_divider #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .q       (q),
        .r       (r),
        .divzero (divzero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Entered #1 after a clock edge; start is taken at the next edge (k=1).
    // Every edge k is then checked for busy/done; results when done is high,
    // held outputs while busy. Returns #1 after an edge with the DUT idle.
    task automatic run_div(input logic [N-1:0] xi, input logic [N-1:0] yi,
                           input logic [N-1:0] eq, input logic [N-1:0] er,
                           input logic edz, input bit restart, input string nm);
        bit exp_busy, exp_done;
        x = xi;
        y = yi;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x = ~xi;
        y = ~yi;
        for (int k = 1; k <= int'(N) + 3; k++) begin
            exp_busy = (yi != 0) && (k <= int'(N));
            exp_done = (yi != 0) ? (k == int'(N) + 1) : (k == 1);
            check({nm, "_busy"}, int'(busy), int'(exp_busy));
            check({nm, "_done"}, int'(done), int'(exp_done));
            if (exp_done) begin
                check({nm, "_q"}, int'(q), int'(eq));
                check({nm, "_r"}, int'(r), int'(er));
                check({nm, "_divzero"}, int'(divzero), int'(edz));
            end
            if (exp_busy) begin
                check({nm, "_q_hold"}, int'(q), prev_q);
                check({nm, "_r_hold"}, int'(r), prev_r);
            end
            if (restart && k == 2) begin
                start = 1'b1;
                x = 4'd6;
                y = 4'd2;
            end
            if (restart && k == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        prev_q = int'(eq);
        prev_r = int'(er);
    endtask

    initial begin
        vecs[0] = '{vx: 4'd13, vy: 4'd4,  eq: 4'd3,  er: 4'd1, edz: 1'b0, restart: 1'b0, name: "x13_y4"};
        vecs[1] = '{vx: 4'd15, vy: 4'd1,  eq: 4'd15, er: 4'd0, edz: 1'b0, restart: 1'b0, name: "x15_y1"};
        vecs[2] = '{vx: 4'd3,  vy: 4'd7,  eq: 4'd0,  er: 4'd3, edz: 1'b0, restart: 1'b0, name: "x3_y7"};
        vecs[3] = '{vx: 4'd15, vy: 4'd15, eq: 4'd1,  er: 4'd0, edz: 1'b0, restart: 1'b0, name: "x15_y15"};
        vecs[4] = '{vx: 4'd9,  vy: 4'd0,  eq: 4'd15, er: 4'd9, edz: 1'b1, restart: 1'b0, name: "x9_y0"};
        vecs[5] = '{vx: 4'd13, vy: 4'd4,  eq: 4'd3,  er: 4'd1, edz: 1'b0, restart: 1'b1, name: "restart_ignored"};

        rst = 1'b1;
        start = 1'b0;
        x = '0;
        y = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_q", int'(q), 0);
        check("reset_r", int'(r), 0);
        check("reset_divzero", int'(divzero), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_div(vecs[i].vx, vecs[i].vy, vecs[i].eq, vecs[i].er,
                    vecs[i].edz, vecs[i].restart, vecs[i].name);

        // Reset two edges into RUN aborts with all outputs cleared.
        x = 4'd13;
        y = 4'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_q", int'(q), 0);
        check("abort_r", int'(r), 0);
        check("abort_divzero", int'(divzero), 0);
        prev_q = 0;
        prev_r = 0;
        // Start on the very first edge after reset deasserts.
        rst = 1'b0;
        run_div(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1'b0, "after_abort");

        for (int xx = 0; xx < 16; xx++)
            for (int yy = 1; yy < 16; yy++)
                run_div(4'(xx), 4'(yy), 4'(xx / yy), 4'(xx % yy), 1'b0, 1'b0, "sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
